// File: rtl/idct_8x8_core.sv
// ---------------------------------------------------------------------------
// idct_8x8_core
//
// Inverse 2-D 8x8 DCT. A block of 64 signed coefficients is loaded in raster
// order and transformed row-wise into a transpose buffer. The columns are then
// transformed, level-shifted by +128 and clamped into an 8-bit pixel buffer.
// The pixels are streamed out in raster order. One shared MAC does all the
// arithmetic, so each of the 128 transform outputs takes 8 cycles.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   coefficient beat valid
//   in_ready   coefficient accepted (high only while loading)
//   in_coef    signed 16-bit coefficient F[k1][k2], k1 = row (major)
//   out_valid  pixel beat valid (high only while streaming out)
//   out_ready  downstream accepts the pixel
//   out_pixel  unsigned 8-bit pixel p[n1][n2], n1 = row (major)
//   busy       block is in the row, column or output phase
// ---------------------------------------------------------------------------
module idct_8x8_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_coef,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_pixel,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_ROW,
        S_COL,
        S_OUT
    } state_t;

    state_t state;
    state_t state_next;

    // idx addresses the beat in LOAD/OUT and the output element in ROW/COL;
    // k is the summation index of the running MAC.
    logic [5:0]         idx;
    logic [2:0]         k;
    logic signed [31:0] acc;

    logic signed [15:0] coef_buf [64];
    logic signed [15:0] tr_buf   [64];
    logic [7:0]         pix_buf  [64];

    logic signed [15:0] mac_a;
    logic signed [9:0]  mac_c;
    logic signed [25:0] prod;
    logic signed [31:0] acc_sum;
    logic signed [31:0] rnd;
    logic signed [31:0] lvl;
    logic signed [15:0] t_val;
    logic [7:0]         pix_val;
    logic               last_mac;

    // c(k,n) = round(256 * a(k) * cos((2n+1)k*pi/16)). The phase (2n+1)k is
    // reduced mod 32 (a full turn), folded into [0,16] and then into [0,8]
    // with a sign flip, leaving a 9-entry magnitude table for 128*cos.
    function automatic logic signed [9:0] cos_lut(input logic [2:0] kk,
                                                  input logic [2:0] nn);
        logic [4:0] m;
        logic       neg;
        logic [7:0] mag;
        m = {1'b0, nn, 1'b1} * {2'b00, kk};
        if (m > 5'd16) m = 5'd0 - m;
        neg = (m > 5'd8);
        if (neg) m = 5'd16 - m;
        case (m)
            5'd0:    mag = 8'd128;
            5'd1:    mag = 8'd126;
            5'd2:    mag = 8'd118;
            5'd3:    mag = 8'd106;
            5'd4:    mag = 8'd91;
            5'd5:    mag = 8'd71;
            5'd6:    mag = 8'd49;
            5'd7:    mag = 8'd25;
            default: mag = 8'd0;
        endcase
        if (kk == 3'd0) return 10'sd91;
        return neg ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
    endfunction

    // Shared MAC datapath. ROW sums along a coefficient row against c(k2,n2);
    // COL sums down a transpose-buffer column against c(k1,n1).
    always_comb begin
        if (state == S_COL) begin
            mac_a = tr_buf[{k, idx[2:0]}];
            mac_c = cos_lut(k, idx[5:3]);
        end else begin
            mac_a = coef_buf[{idx[5:3], k}];
            mac_c = cos_lut(k, idx[2:0]);
        end
        prod     = mac_a * mac_c;
        // The first product of each output restarts the sum instead of
        // needing a separate clear cycle.
        acc_sum  = ((k == 3'd0) ? 32'sd0 : acc) + 32'(prod);
        rnd      = (acc_sum + 32'sd128) >>> 8;
        lvl      = rnd + 32'sd128;
        last_mac = (k == 3'd7);

        if (rnd > 32'sd32767)       t_val = 16'sh7fff;
        else if (rnd < -32'sd32768) t_val = 16'sh8000;
        else                        t_val = rnd[15:0];

        if (lvl < 32'sd0)          pix_val = 8'd0;
        else if (lvl > 32'sd255)   pix_val = 8'd255;
        else                       pix_val = lvl[7:0];
    end

    // NOTE: every signal driven by an always_comb gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_pixel  = 8'd0;
        busy       = 1'b1;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && idx == 6'd63) state_next = S_ROW;
            end
            S_ROW: begin
                if (last_mac && idx == 6'd63) state_next = S_COL;
            end
            S_COL: begin
                if (last_mac && idx == 6'd63) state_next = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_pixel = pix_buf[idx];
                if (out_ready && idx == 6'd63) state_next = S_LOAD;
            end
            default: state_next = S_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
            idx   <= 6'd0;
            k     <= 3'd0;
            acc   <= 32'sd0;
        end else begin
            state <= state_next;
            case (state)
                S_LOAD: if (in_valid) idx <= idx + 6'd1;
                S_ROW, S_COL: begin
                    acc <= acc_sum;
                    k   <= k + 3'd1;
                    if (last_mac) idx <= idx + 6'd1;
                end
                S_OUT: if (out_ready) idx <= idx + 6'd1;
                default: ;
            endcase
        end
    end

    // NOTE: the buffers are plain storage with no reset; every entry is
    // rewritten before it is read, so reset logic would only cost area.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid) coef_buf[idx] <= $signed(in_coef);
        if (state == S_ROW && last_mac)  tr_buf[idx]   <= t_val;
        if (state == S_COL && last_mac)  pix_buf[idx]  <= pix_val;
    end

endmodule

// File: tb/tb_idct_8x8_core.sv
// ---------------------------------------------------------------------------
// tb_idct_8x8_core
//
// Directed bench for idct_8x8_core: zero / DC / clamping blocks with
// hand-computed pixels, random blocks compared against a floating-point-derived
// cosine table and integer model, reset during ROW and during a stalled OUT,
// and back-to-back blocks with in_valid held high.
// ---------------------------------------------------------------------------
module tb_idct_8x8_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_coef = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_pixel;
    logic        busy;

    idct_8x8_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef int blk_t [64];

    int checks = 0;
    int errors = 0;
    int ctab [8][8];
    int last_in_cyc;
    int first_valid_cyc;
    int last_out_cyc;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference of the stated integer arithmetic, using the bench's own table.
    task automatic ref_idct(input blk_t f, output blk_t p);
        longint acc;
        longint r;
        int     t [64];
        for (int k1 = 0; k1 < 8; k1++)
            for (int n2 = 0; n2 < 8; n2++) begin
                acc = 0;
                for (int k2 = 0; k2 < 8; k2++)
                    acc += longint'(f[k1*8+k2]) * ctab[k2][n2];
                r = (acc + 128) >>> 8;
                if (r > 32767) r = 32767;
                if (r < -32768) r = -32768;
                t[k1*8+n2] = int'(r);
            end
        for (int n1 = 0; n1 < 8; n1++)
            for (int n2 = 0; n2 < 8; n2++) begin
                acc = 0;
                for (int k1 = 0; k1 < 8; k1++)
                    acc += longint'(t[k1*8+n2]) * ctab[k1][n1];
                r = ((acc + 128) >>> 8) + 128;
                if (r < 0) r = 0;
                if (r > 255) r = 255;
                p[n1*8+n2] = int'(r);
            end
    endtask

    task automatic feed(input blk_t b, input bit gaps, input bit hold);
        int i = 0;
        int guard = 0;
        bit hs;
        while (i < 64 && guard < 5000) begin
            @(negedge clk);
            if (gaps && $urandom_range(3) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_coef  = 16'(b[i]);
            end
            hs = in_valid && in_ready;
            if (hs && i == 63) last_in_cyc = cyc;
            @(posedge clk);
            if (hs) i++;
            guard++;
        end
        check("feed_beats", i, 64);
        if (!hold) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic collect(input blk_t exp, input int count, input bit stalls,
                           input string tag);
        int j = 0;
        int guard = 0;
        bit prev_stall = 1'b0;
        int prev_px = 0;
        while (j < count && guard < 5000) begin
            @(negedge clk);
            out_ready = stalls ? ($urandom_range(2) != 0) : 1'b1;
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (prev_stall) check($sformatf("%s_hold%0d", tag, j), out_pixel, prev_px);
                if (out_ready) begin
                    check($sformatf("%s_px%0d", tag, j), out_pixel, exp[j]);
                    if (j == 63) begin
                        last_out_cyc = cyc;
                        check($sformatf("%s_ready_last_out", tag), in_ready, 0);
                    end
                    j++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_px    = out_pixel;
                end
            end
            @(posedge clk);
            guard++;
        end
        check($sformatf("%s_beats", tag), j, count);
    endtask

    task automatic run_block(input blk_t b, input blk_t exp, input bit gaps,
                             input bit stalls, input string tag);
        first_valid_cyc = -1;
        feed(b, gaps, 1'b1);
        @(negedge clk);
        check({tag, "_ready_drop"}, in_ready, 0);
        check({tag, "_busy"}, busy, 1);
        in_valid = 1'b0;
        collect(exp, 64, stalls, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_pixel"}, out_pixel, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t zero_b, dc64, neg_b, pos_b, rnd1, rnd2, rnd3, rnd4;
        blk_t px128, px136, px0, px255, exp1, exp2, exp3, exp4;
        real  pi;
        real  a;

        pi = 3.14159265358979;
        for (int kk = 0; kk < 8; kk++)
            for (int nn = 0; nn < 8; nn++) begin
                a = (kk == 0) ? $sqrt(0.125) : 0.5;
                ctab[kk][nn] = int'($floor(256.0 * a *
                               $cos(real'((2*nn+1)*kk) * pi / 16.0) + 0.5));
            end

        for (int i = 0; i < 64; i++) begin
            zero_b[i] = 0;
            dc64[i]   = (i == 0) ? 64 : 0;
            neg_b[i]  = (i == 0) ? -2048 : 0;
            pos_b[i]  = (i == 0) ? 2047 : 0;
            rnd1[i]   = int'($urandom_range(2047)) - 1024;
            rnd2[i]   = int'($urandom_range(2047)) - 1024;
            rnd3[i]   = int'($urandom_range(2047)) - 1024;
            rnd4[i]   = int'($urandom_range(2047)) - 1024;
            px128[i]  = 128;
            px136[i]  = 136;
            px0[i]    = 0;
            px255[i]  = 255;
        end
        ref_idct(rnd1, exp1);
        ref_idct(rnd2, exp2);
        ref_idct(rnd3, exp3);
        ref_idct(rnd4, exp4);

        // Power-on reset.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Zero block: latency and streaming rate.
        run_block(zero_b, px128, 1'b0, 1'b0, "zero");
        check("zero_latency", first_valid_cyc - last_in_cyc, 1025);
        check("zero_stream", last_out_cyc - first_valid_cyc, 63);

        // DC and clamping blocks.
        run_block(dc64, px136, 1'b0, 1'b0, "dc64");
        run_block(neg_b, px0, 1'b0, 1'b0, "neg");
        run_block(pos_b, px255, 1'b0, 1'b0, "pos");

        // Random blocks with input gaps and output stalls.
        run_block(rnd1, exp1, 1'b1, 1'b1, "rnd1");
        run_block(rnd2, exp2, 1'b0, 1'b1, "rnd2");

        // Reset in the middle of ROW while holding a different block.
        feed(neg_b, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check("mid_row_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_row");
        @(negedge clk);
        rst_n = 1'b1;
        run_block(dc64, px136, 1'b0, 1'b0, "after_row");

        // Reset during OUT, stalled at pixel 20.
        feed(rnd3, 1'b0, 1'b0);
        first_valid_cyc = -1;
        collect(exp3, 20, 1'b0, "pre_abort");
        @(negedge clk);
        out_ready = 1'b0;
        repeat (4) begin
            check("stall20_valid", out_valid, 1);
            check("stall20_pixel", out_pixel, exp3[20]);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_out");
        @(negedge clk);
        rst_n = 1'b1;
        run_block(dc64, px136, 1'b1, 1'b0, "after_out");

        // Back-to-back blocks, in_valid held high across ROW/COL/OUT.
        first_valid_cyc = -1;
        fork
            begin
                feed(pos_b, 1'b0, 1'b1);
                feed(rnd4, 1'b0, 1'b0);
            end
            begin
                collect(px255, 64, 1'b0, "b2b_a");
                @(negedge clk);
                check("b2b_ready_rise", in_ready, 1);
                check("b2b_rise_cycle", cyc - last_out_cyc, 1);
                collect(exp4, 64, 1'b0, "b2b_b");
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
